// File: rtl/maze_lookup_arbiter_if.sv
// Request/ROM/response bundle for maze_lookup_arbiter.
// slave = arbiter side; master = requesters plus maze ROM.
interface maze_lookup_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10
);
    logic [NUM_REQ-1:0]   req;
    logic [6*NUM_REQ-1:0] req_row;
    logic [5*NUM_REQ-1:0] req_col;
    logic [NUM_REQ-1:0]   gnt;
    logic                 rom_en;
    logic [ADDR_W-1:0]    rom_addr;
    logic                 rom_data;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic                 rsp_path;

    modport slave (
        input  req, req_row, req_col, rom_data,
        output gnt, rom_en, rom_addr, rsp_valid, rsp_path
    );

    modport master (
        output req, req_row, req_col, rom_data,
        input  gnt, rom_en, rom_addr, rsp_valid, rsp_path
    );
endinterface

// File: rtl/maze_lookup_arbiter.sv
// Round-robin arbiter sharing the single-port maze wall ROM; 3-stage lookup pipeline.
// Define MAZE_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin pool.
module maze_lookup_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int COLS    = 28,
    parameter int ROWS    = 36,
    parameter int ADDR_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    maze_lookup_arbiter_if.slave  bus
);

    localparam int         IDX_W   = $clog2(NUM_REQ);
    localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);
    localparam logic [4:0] COL_MAX = 5'(COLS - 1);

    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [NUM_REQ-1:0] pool;
    logic [NUM_REQ-1:0] rr_pool;
    logic               rom_en_q;
    logic               s2_valid_q;
    logic               rsp_path_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [ADDR_W-1:0]  addr_calc;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   s1_idx_q;
    logic [IDX_W-1:0]   s2_idx_q;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               rr_found;
    logic               win_found;
    logic               ptr_upd;
    logic [5:0]         row_sel;
    logic [5:0]         row_clamp;
    logic [4:0]         col_sel;
    logic [4:0]         col_clamp;
    logic [5:0]         row_arr [NUM_REQ];
    logic [4:0]         col_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign row_arr[g] = bus.req_row[6*g +: 6];
        assign col_arr[g] = bus.req_col[5*g +: 5];
    end

    // A requester granted this cycle may still hold req; that level is not a new request yet.
    assign pool = bus.req & ~gnt_q;

`ifdef MAZE_ARB_PRIO0_EN
    assign rr_pool = pool & ~NUM_REQ'(1);
`else
    assign rr_pool = pool;
`endif

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!rr_found && rr_pool[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        win_found = rr_found;
        win_idx   = rr_idx;
        ptr_upd   = rr_found;
`ifdef MAZE_ARB_PRIO0_EN
        // Requester 0 bypasses the rotation and leaves the pointer where it was.
        if (pool[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
            ptr_upd   = 1'b0;
        end
`endif
    end

    always_comb begin
        row_sel   = row_arr[win_idx];
        col_sel   = col_arr[win_idx];
        row_clamp = (row_sel > ROW_MAX) ? ROW_MAX : row_sel;
        col_clamp = (col_sel > COL_MAX) ? COL_MAX : col_sel;
        addr_calc = ADDR_W'(row_clamp) * ADDR_W'(COLS) + ADDR_W'(col_clamp);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q       <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            s1_idx_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_idx_q    <= '0;
            rsp_valid_q <= '0;
            rsp_path_q  <= 1'b0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
        end else begin
            gnt_q    <= win_found ? (NUM_REQ'(1) << win_idx) : '0;
            rom_en_q <= win_found;
            s1_idx_q <= win_idx;
            if (win_found) begin
                rom_addr_q <= addr_calc;
            end
            if (ptr_upd) begin
                ptr_q <= win_idx;
            end

            s2_valid_q <= rom_en_q;
            s2_idx_q   <= s1_idx_q;

            rsp_valid_q <= s2_valid_q ? (NUM_REQ'(1) << s2_idx_q) : '0;
            if (s2_valid_q) begin
                rsp_path_q <= bus.rom_data;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rom_en    = rom_en_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_path  = rsp_path_q;

endmodule

// File: tb/tb_maze_lookup_arbiter.sv
// Directed bench for maze_lookup_arbiter; ROM content is path = addr[0] ^ addr[3].
module tb_maze_lookup_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    maze_lookup_arbiter_if #(.NUM_REQ(4), .ADDR_W(10)) bus ();

    maze_lookup_arbiter #(
        .NUM_REQ(4),
        .COLS   (28),
        .ROWS   (36),
        .ADDR_W (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic rom_bit(input logic [9:0] a);
        return a[0] ^ a[3];
    endfunction

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom_bit(bus.rom_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_tile(input int i, input int row, input int col);
        bus.req_row[6*i +: 6] = 6'(row);
        bus.req_col[5*i +: 5] = 5'(col);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    int         addr_tab [4] = '{0, 29, 58, 87};
    logic [3:0] path_tab     = 4'b1100;
`ifdef MAZE_ARB_PRIO0_EN
    int         seq [8] = '{0, 1, 0, 2, 0, 3, 0, 1};
`else
    int         seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

    initial begin
        bus.req     = '0;
        bus.req_row = '0;
        bus.req_col = '0;
        do_reset();

        check("reset_gnt",       bus.gnt,       0);
        check("reset_rom_en",    bus.rom_en,    0);
        check("reset_rom_addr",  bus.rom_addr,  0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_path",  bus.rsp_path,  0);

        // Single lookup from requester 1 at tile (4,1)
        set_tile(1, 4, 1);
        bus.req = 4'b0010;
        step();
        check("t1_gnt",      bus.gnt,      4'b0010);
        check("t1_rom_en",   bus.rom_en,   1);
        check("t1_rom_addr", bus.rom_addr, 113);
        bus.req = '0;
        step();
        check("t1_gnt_off",    bus.gnt,       0);
        check("t1_rom_en_off", bus.rom_en,    0);
        check("t1_rsp_early",  bus.rsp_valid, 0);
        check("t1_addr_hold",  bus.rom_addr,  113);
        step();
        check("t1_rsp_valid", bus.rsp_valid, 4'b0010);
        check("t1_rsp_path",  bus.rsp_path,  1);
        step();
        check("t1_rsp_off",   bus.rsp_valid, 0);
        check("t1_path_hold", bus.rsp_path,  1);

        // All four requesting continuously
        do_reset();
        for (int i = 0; i < 4; i++) set_tile(i, i, i);
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("t2_gnt_%0d", k),  bus.gnt,      4'b0001 << seq[k]);
            check($sformatf("t2_addr_%0d", k), bus.rom_addr, addr_tab[seq[k]]);
            if (k >= 2) begin
                check($sformatf("t2_rsp_%0d", k),  bus.rsp_valid, 4'b0001 << seq[k-2]);
                check($sformatf("t2_path_%0d", k), bus.rsp_path,  path_tab[seq[k-2]]);
            end
        end
        bus.req = '0;

        // Clamp to the last tile, then the origin tile
        do_reset();
        set_tile(0, 40, 31);
        set_tile(1, 0, 0);
        bus.req = 4'b0001;
        step();
        check("t3_gnt_a",  bus.gnt,      4'b0001);
        check("t3_addr_a", bus.rom_addr, 1007);
        bus.req = 4'b0010;
        step();
        check("t3_gnt_b",  bus.gnt,      4'b0010);
        check("t3_addr_b", bus.rom_addr, 0);
        bus.req = '0;
        step();
        check("t3_rsp_a",  bus.rsp_valid, 4'b0001);
        check("t3_path_a", bus.rsp_path,  0);
        step();
        check("t3_rsp_b",  bus.rsp_valid, 4'b0010);
        check("t3_path_b", bus.rsp_path,  0);

        // Reset with two lookups in flight
        do_reset();
        set_tile(0, 0, 0);
        set_tile(1, 1, 1);
        bus.req = 4'b0011;
        step();
        check("t4_gnt_a", bus.gnt, 4'b0001);
        bus.req = 4'b0010;
        step();
        check("t4_gnt_b", bus.gnt, 4'b0010);
        bus.req = '0;
        reset   = 1'b1;
        step();
        check("t4_rst_gnt",    bus.gnt,       0);
        check("t4_rst_rom_en", bus.rom_en,    0);
        check("t4_rst_rsp",    bus.rsp_valid, 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t4_no_rsp_%0d", k), bus.rsp_valid, 0);
        end
        bus.req = 4'b1111;
        step();
        check("t4_first_after_rst", bus.gnt, 4'b0001);
        bus.req = '0;

        // Requesters 2 and 3 pulse; 2 drops once granted
        do_reset();
        set_tile(2, 1, 2);
        set_tile(3, 2, 3);
        bus.req = 4'b1100;
        step();
        check("t5_gnt_2",  bus.gnt,      4'b0100);
        check("t5_addr_2", bus.rom_addr, 30);
        bus.req = 4'b1000;
        step();
        check("t5_gnt_3",  bus.gnt,      4'b1000);
        check("t5_addr_3", bus.rom_addr, 59);
        bus.req = '0;
        step();
        check("t5_gnt_none_a", bus.gnt,       0);
        check("t5_rsp_2",      bus.rsp_valid, 4'b0100);
        check("t5_path_2",     bus.rsp_path,  1);
        step();
        check("t5_gnt_none_b", bus.gnt,       0);
        check("t5_rsp_3",      bus.rsp_valid, 4'b1000);
        check("t5_path_3",     bus.rsp_path,  0);
        step();
        check("t5_gnt_none_c", bus.gnt,       0);
        check("t5_rsp_done",   bus.rsp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
